tnn_neuron_scheduler: RTL and testbench

TNN_NEURON_SCHEDULER -- requirements
Module: tnn_neuron_scheduler

---
 rtl/tnn_neuron_scheduler.sv | 148 ++++++++++++++
 tb/tb_tnn_neuron_scheduler.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tnn_neuron_scheduler.sv
// ---------------------------------------------------------------------------
// tnn_neuron_scheduler
//
// Shares one serial neuron unit between NREQ requesters. A round-robin
// arbiter picks a requester in IDLE. Its six W-bit operands a..f are then
// accumulated one per cycle: a, b into pos_acc and c..f into neg_acc. The
// strict comparison pos_acc > neg_acc is returned with the requester index.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   req_valid   per-requester evaluation request
//   req_ready   per-requester grant, one-hot or zero, only in IDLE
//   req_data    requester i owns [i*6W +: 6W], operands a..f LSB first
//   resp_valid  result available (RESP state)
//   resp_ready  consumer accepts result
//   resp_id     index of the requester owning the result
//   resp_out    neuron decision bit
//   busy        high in every state except IDLE
// ---------------------------------------------------------------------------
module tnn_neuron_scheduler #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned W    = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req_valid,
   output logic [NREQ-1:0]         req_ready,
   input  logic [NREQ*6*W-1:0]     req_data,
   output logic                    resp_valid,
   input  logic                    resp_ready,
   output logic [$clog2(NREQ)-1:0] resp_id,
   output logic                    resp_out,
   output logic                    busy
);

   localparam int unsigned IdW = $clog2(NREQ);
   localparam int unsigned DW  = 6 * W;

   typedef enum logic [1:0] {StIdle, StAccum, StCmp, StResp} state_e;

   state_e         state_q, state_d;
   logic [2:0]     cnt_q, cnt_d;
   logic [IdW-1:0] ptr_q, ptr_d;
   logic [IdW-1:0] id_q, id_d;
   logic [DW-1:0]  data_q, data_d;
   logic [W:0]     pos_q, pos_d;
   logic [W+1:0]   neg_q, neg_d;
   logic [IdW-1:0] rid_q, rid_d;
   logic           rout_q, rout_d;

   logic [NREQ-1:0] grant;
   logic [IdW-1:0]  grant_idx;
   logic            grant_vld;
   logic [W-1:0]    op;

   // Round-robin search upward from ptr_q with wrap-around.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      grant_vld = 1'b0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         int unsigned idx;
         idx = 32'(ptr_q) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!grant_vld && req_valid[idx]) begin
            grant_vld = 1'b1;
            grant_idx = IdW'(idx);
         end
      end
      if (grant_vld) grant[grant_idx] = 1'b1;
   end

   // Grant is only visible in IDLE and is forced low while rst is held.
   assign req_ready  = (state_q == StIdle && !rst) ? grant : '0;
   assign busy       = (state_q != StIdle);
   assign resp_valid = (state_q == StResp);
   assign resp_id    = rid_q;
   assign resp_out   = rout_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ptr_d   = ptr_q;
      id_d    = id_q;
      data_d  = data_q;
      pos_d   = pos_q;
      neg_d   = neg_q;
      rid_d   = rid_q;
      rout_d  = rout_q;
      op      = data_q[cnt_q*W +: W];

      case (state_q)
         StIdle: begin
            if (grant_vld) begin
               data_d  = req_data[grant_idx*DW +: DW];
               id_d    = grant_idx;
               ptr_d   = (grant_idx == IdW'(NREQ - 1)) ? '0 : grant_idx + IdW'(1);
               pos_d   = '0;
               neg_d   = '0;
               cnt_d   = '0;
               state_d = StAccum;
            end
         end
         StAccum: begin
            // Operands a, b feed the positive side; c..f the negative side.
            if (cnt_q < 3'd2) pos_d = pos_q + {1'b0, op};
            else              neg_d = neg_q + {2'b00, op};
            if (cnt_q == 3'd5) state_d = StCmp;
            else               cnt_d   = cnt_q + 3'd1;
         end
         StCmp: begin
            rout_d  = ({1'b0, pos_q} > neg_q);
            rid_d   = id_q;
            state_d = StResp;
         end
         StResp: begin
            if (resp_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         ptr_q   <= '0;
         id_q    <= '0;
         data_q  <= '0;
         pos_q   <= '0;
         neg_q   <= '0;
         rid_q   <= '0;
         rout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
         id_q    <= id_d;
         data_q  <= data_d;
         pos_q   <= pos_d;
         neg_q   <= neg_d;
         rid_q   <= rid_d;
         rout_q  <= rout_d;
      end
   end

endmodule

// File: tb/tb_tnn_neuron_scheduler.sv
// ---------------------------------------------------------------------------
// tb_tnn_neuron_scheduler
//
// Self-checking bench: a vector table, hand-written corner sequences
// (round-robin under full load, response back-pressure, reset mid-ACCUM)
// and randomized requests against a small arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_tnn_neuron_scheduler;

   localparam int NREQ = 4;
   localparam int W    = 3;
   localparam int IdW  = $clog2(NREQ);
   localparam int SW   = 6 * W;
   localparam int DW   = NREQ * SW;

   logic            clk = 1'b0;
   logic            rst;
   logic [NREQ-1:0] req_valid;
   logic [NREQ-1:0] req_ready;
   logic [DW-1:0]   req_data;
   logic            resp_valid;
   logic            resp_ready;
   logic [IdW-1:0]  resp_id;
   logic            resp_out;
   logic            busy;

   tnn_neuron_scheduler #(.NREQ(NREQ), .W(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_data   (req_data),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_id    (resp_id),
      .resp_out   (resp_out),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int tests = 0;
   int fails = 0;
   int ptr_m = 0;
   int acc_cyc[$];

   typedef struct {
      int          id;
      logic [SW-1:0] ops;
      bit          exp;
   } vec_t;
   vec_t tbl[7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [SW-1:0] pack6(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [W-1:0] c, input logic [W-1:0] d,
                                           input logic [W-1:0] e, input logic [W-1:0] f);
      return {f, e, d, c, b, a};
   endfunction

   // First requester with valid set, searching upward from p with wrap.
   function automatic int model_grant(input logic [NREQ-1:0] m, input int p);
      for (int k = 0; k < NREQ; k++) begin
         if (m[(p + k) % NREQ]) return (p + k) % NREQ;
      end
      return -1;
   endfunction

   function automatic bit model_out(input logic [SW-1:0] s);
      int pos, neg;
      pos = int'(s[0 +: W]) + int'(s[W +: W]);
      neg = int'(s[2*W +: W]) + int'(s[3*W +: W]) + int'(s[4*W +: W]) + int'(s[5*W +: W]);
      return pos > neg;
   endfunction

   // One full transaction starting at posedge+1 in IDLE; returns the observed id/out.
   task automatic txn(input logic [NREQ-1:0] mask, input logic [DW-1:0] data, input bit keep,
                      input int stall, output int got_id, output logic got_out);
      int g, n;
      bit eo, any_rdy, ok;
      logic [IdW-1:0] sid;
      logic sout;
      req_valid  = mask;
      req_data   = data;
      resp_ready = (stall == 0);
      #1;
      g  = model_grant(mask, ptr_m);
      eo = model_out(data[g*SW +: SW]);
      check("grant", req_ready, 32'(1 << g));
      tick();
      acc_cyc.push_back(cyc);
      ptr_m = (g + 1) % NREQ;
      if (!keep) req_valid = '0;
      check("busy_after_accept", busy, 1);
      n = 0;
      any_rdy = 0;
      while (!resp_valid && n < 20) begin
         if (req_ready != '0) any_rdy = 1;
         tick();
         n++;
      end
      check("latency", n, 7);
      check("no_grant_while_busy", any_rdy, 0);
      got_id  = int'(resp_id);
      got_out = resp_out;
      if (n >= 20) return;
      check("resp_id", resp_id, g);
      check("resp_out", resp_out, eo);
      if (stall > 0) begin
         sid = resp_id;
         sout = resp_out;
         ok = 1;
         repeat (stall) begin
            tick();
            if (!(resp_valid && resp_id == sid && resp_out == sout && req_ready == '0)) ok = 0;
         end
         check("stall_hold", ok, 1);
         resp_ready = 1'b1;
         #1;
         check("still_resp", busy, 1);
      end
      tick();
      check("idle_after_resp", busy, 0);
      check("resp_drop", resp_valid, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int gid;
      logic gout;
      logic [DW-1:0] d;
      bit seen;

      tbl[0] = '{0, pack6(7, 7, 3, 3, 3, 3), 1'b1};
      tbl[1] = '{2, pack6(4, 4, 2, 2, 2, 2), 1'b0};
      tbl[2] = '{2, pack6(3, 3, 2, 2, 2, 2), 1'b0};
      tbl[3] = '{1, pack6(0, 0, 0, 0, 0, 0), 1'b0};
      tbl[4] = '{3, pack6(7, 7, 0, 0, 0, 0), 1'b1};
      tbl[5] = '{3, pack6(7, 7, 7, 7, 0, 0), 1'b0};
      tbl[6] = '{1, pack6(1, 0, 0, 0, 0, 0), 1'b1};

      // Reset state, with every requester asking.
      rst        = 1'b1;
      req_valid  = '1;
      req_data   = '0;
      resp_ready = 1'b0;
      @(posedge clk);
      #1;
      check("rst_req_ready", req_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_resp_valid", resp_valid, 0);
      check("rst_resp_id", resp_id, 0);
      check("rst_resp_out", resp_out, 0);
      tick();
      rst = 1'b0;
      ptr_m = 0;

      // Full load: order 0,1,2,3,0, accepts exactly 9 cycles apart.
      acc_cyc.delete();
      for (int i = 0; i < 5; i++) begin
         for (int b = 0; b < DW; b++) d[b] = 1'($urandom_range(0, 1));
         txn('1, d, 1'b1, 0, gid, gout);
         check("rr_order", gid, i % NREQ);
      end
      for (int i = 1; i < acc_cyc.size(); i++) check("accept_spacing", acc_cyc[i] - acc_cyc[i-1], 9);
      req_valid = '0;

      // Vector table.
      for (int i = 0; i < 7; i++) begin
         d = '0;
         d[tbl[i].id*SW +: SW] = tbl[i].ops;
         txn(NREQ'(1 << tbl[i].id), d, 1'b0, 0, gid, gout);
         check("tbl_id", gid, tbl[i].id);
         check("tbl_out", gout, tbl[i].exp);
      end

      // Back-pressure: resp_ready low for 5 cycles in RESP.
      d = '0;
      d[1*SW +: SW] = pack6(5, 6, 1, 1, 1, 1);
      txn(4'b0110, d, 1'b1, 5, gid, gout);
      req_valid = '0;

      // Randomized traffic.
      for (int i = 0; i < 20; i++) begin
         for (int b = 0; b < DW; b++) d[b] = 1'($urandom_range(0, 1));
         txn(NREQ'($urandom_range(1, (1 << NREQ) - 1)), d, 1'($urandom_range(0, 1)),
             $urandom_range(0, 3), gid, gout);
      end
      req_valid = '0;

      // Reset during the 3rd ACCUM cycle aborts the evaluation.
      d = '0;
      d[1*SW +: SW] = pack6(7, 7, 0, 0, 0, 0);
      txn(4'b0010, d, 1'b0, 0, gid, gout);
      req_valid = 4'b0100;
      req_data  = '0;
      req_data[2*SW +: SW] = pack6(7, 7, 0, 0, 0, 0);
      #1;
      check("pre_abort_grant", req_ready, 4'b0100);
      tick();
      req_valid = '0;
      tick();
      tick();
      #2;
      rst       = 1'b1;
      req_valid = '1;
      #1;
      check("abort_busy", busy, 0);
      check("abort_resp_valid", resp_valid, 0);
      check("abort_resp_id", resp_id, 0);
      check("abort_resp_out", resp_out, 0);
      check("abort_req_ready", req_ready, 0);
      tick();
      rst       = 1'b0;
      req_valid = '0;
      ptr_m     = 0;
      seen      = 0;
      repeat (12) begin
         if (resp_valid) seen = 1;
         tick();
      end
      check("no_resp_after_abort", seen, 0);
      d = '0;
      txn('1, d, 1'b0, 0, gid, gout);
      check("grant_from_ptr0", gid, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
